// File: rtl/vec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_ctrl_pkg
// Description : Shared definitions for the vector-instruction sequencer:
//               sequencer state enum, vector opcode constants and the
//               TLoad all-ones helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vec_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_REQ = 3'd1,
    S_ST_REQ = 3'd2,
    S_ADD    = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [1:0] OP_VLOAD  = 2'b00;
  localparam logic [1:0] OP_VSTORE = 2'b01;
  localparam logic [1:0] OP_VADD   = 2'b10;
  localparam logic [1:0] OP_ILL    = 2'b11;

  // Widest vector the helper can describe; callers cast down to VLEN bits.
  localparam int TLOAD_MAX_W = 64;

  // Returns a mask with the low vlen bits set (all T-registers enabled).
  function automatic logic [TLOAD_MAX_W-1:0] tload_all_ones(input int vlen);
    logic [TLOAD_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < TLOAD_MAX_W; i++) begin
      if (i < vlen) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_elem_counter.sv
`default_nettype none
// ============================================================================
// Module      : vec_elem_counter
// Description : Element index counter with synchronous clear, increment and
//               terminal-count flag. Wraps to 0 when incremented at VLEN-1.
// Ports       : i_clock   - rising-edge clock
//               i_reset_n - asynchronous active-low reset
//               i_clr     - clear count to 0
//               i_inc     - advance to next element
//               o_count   - current element index
//               o_tc      - count is at the last element (VLEN-1)
// Revision    : 1.0 - initial release
// ============================================================================
module vec_elem_counter #(
  parameter int VLEN  = 4,
  parameter int IDX_W = $clog2(VLEN)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(VLEN - 1);

  logic [IDX_W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      // Explicit wrap so non-power-of-two VLEN never shows an index >= VLEN.
      r_count <= o_tc ? '0 : r_count + IDX_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/vec_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module      : vec_seq_fsm
// Description : Vector-instruction sequencer. Accepts one VLOAD / VSTORE /
//               VADD per start pulse, walks VLEN elements with memory wait
//               states and drives the element-level datapath controls.
// Ports       : i_clock, i_reset_n     - clock, async active-low reset
//               i_start, i_op          - request and opcode from main FSM
//               i_mem_ready            - memory finished current access
//               o_busy, o_done, o_err  - status / completion / illegal-op
//               o_elem                 - current element index
//               o_mem_read/o_mem_write - memory strobes
//               o_addr_inc             - bump vector address register
//               o_tload                - T-register load enables
//               o_vrf_write            - write T-registers into VRF
//               o_voutsel              - store-data element select
//               o_vadd_en              - lane adders into T-registers
// Revision    : 1.0 - initial release
// ============================================================================
module vec_seq_fsm
  import vec_ctrl_pkg::*;
#(
  parameter int VLEN  = 4,
  parameter int IDX_W = $clog2(VLEN)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_mem_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [IDX_W-1:0] o_elem,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_addr_inc,
  output logic [VLEN-1:0]  o_tload,
  output logic             o_vrf_write,
  output logic [IDX_W-1:0] o_voutsel,
  output logic             o_vadd_en
);

  localparam logic [VLEN-1:0] c_TLOAD_ALL = VLEN'(tload_all_ones(VLEN));
  localparam logic [VLEN-1:0] c_TLOAD_ONE = VLEN'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_cnt_tc;
  logic [IDX_W-1:0] w_elem;

  vec_elem_counter #(
    .VLEN  (VLEN),
    .IDX_W (IDX_W)
  ) u_elem_counter (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clr     (w_cnt_clr),
    .i_inc     (w_cnt_inc),
    .o_count   (w_elem),
    .o_tc      (w_cnt_tc)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_addr_inc  = 1'b0;
    o_tload     = '0;
    o_vrf_write = 1'b0;
    o_voutsel   = '0;
    o_vadd_en   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          // Clearing on every accepted op keeps elem at 0 even after a
          // previous op was aborted by reset or left a stale index.
          w_cnt_clr = (i_op != OP_ILL);
          case (i_op)
            OP_VLOAD:  w_state_nxt = S_LD_REQ;
            OP_VSTORE: w_state_nxt = S_ST_REQ;
            OP_VADD:   w_state_nxt = S_ADD;
            default:   o_err       = 1'b1;
          endcase
        end
      end

      S_LD_REQ: begin
        o_mem_read = 1'b1;
        if (i_mem_ready) begin
          o_tload    = c_TLOAD_ONE << w_elem;
          o_addr_inc = 1'b1;
          w_cnt_inc  = 1'b1;
          if (w_cnt_tc) w_state_nxt = S_WB;
        end
      end

      S_ST_REQ: begin
        o_mem_write = 1'b1;
        o_voutsel   = w_elem;
        if (i_mem_ready) begin
          o_addr_inc = 1'b1;
          w_cnt_inc  = 1'b1;
          if (w_cnt_tc) w_state_nxt = S_DONE;
        end
      end

      S_ADD: begin
        o_vadd_en   = 1'b1;
        o_tload     = c_TLOAD_ALL;
        w_state_nxt = S_WB;
      end

      S_WB: begin
        o_vrf_write = 1'b1;
        w_state_nxt = S_DONE;
      end

      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_elem = w_elem;

endmodule
`default_nettype wire

// File: doc/vec_seq_fsm.md
# vec_seq_fsm

Parametrised vector-instruction sequencer that extends the multicycle control unit to vector operations. The main control FSM hands over one VLOAD, VSTORE or VADD per `start` pulse. This block then steps through VLEN elements, tolerates memory wait states, and drives the element-level datapath controls: memory strobes, T-register loads, vector register file write and store-lane select. It signals completion back to the main FSM with a one-cycle `done`.

## Interface
- VLEN, 4: elements per vector; must be ≥2.
- IDX_W, $clog2(VLEN): element index width.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request from main FSM; sampled only in IDLE
- op  in  2  00 VLOAD, 01 VSTORE, 10 VADD, 11 illegal; sampled with `start`
- mem_ready  in  1  memory completed the current read/write this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse when `start` carries op 11
- elem  out  IDX_W  current element index
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- AddrInc  out  1  increment vector address register
- TLoad  out  VLEN  one-hot or all-ones T-register load enables
- VRFWrite  out  1  write T-registers into vector register file
- Voutsel  out  IDX_W  element selected as store data
- VaddEn  out  1  enable lane adders into T-registers

## Operation
- States: IDLE, LD_REQ, ST_REQ, ADD, WB, DONE.
- IDLE:
  - `start`&op=00 → LD_REQ; op=01 → ST_REQ; op=10 → ADD.
  - op=11: `err`=1 for that cycle and remain in IDLE.
  - Entering any operation clears `elem` to 0.
- LD_REQ:
  - MemRead=1.
  - If mem_ready: TLoad[elem]=1, AddrInc=1, elem+1.
  - If elem==VLEN-1 and mem_ready → WB; else stay.
- ST_REQ:
  - MemWrite=1, Voutsel=elem.
  - If mem_ready: AddrInc=1, elem+1.
  - If elem==VLEN-1 and mem_ready → DONE; else stay.
- ADD: VaddEn=1, TLoad=all ones, → WB.
- WB: VRFWrite=1 → DONE.
- DONE: done=1 → IDLE.
- `start` outside IDLE is ignored; no queuing.
- `elem` wraps from VLEN-1 to 0 on the last accepted element; it is never observed beyond VLEN-1.
- mem_ready outside LD_REQ/ST_REQ is ignored.
- Strobes not listed for a state are 0.

## Timing
- State and `elem` are registers.
- Outputs are combinational from state; TLoad/AddrInc in LD_REQ and AddrInc in ST_REQ also depend on mem_ready (Mealy).
- Reset (reset_n low, any time including mid-vector): state=IDLE and elem=0 immediately. All outputs are 0, including busy, done, err, TLoad and Voutsel.
- With `start` accepted at edge k and mem_ready held high:
  - VLOAD: LD_REQ for cycles k+1..k+VLEN, WB at k+VLEN+1, done at k+VLEN+2.
  - VSTORE: done at k+VLEN+1.
  - VADD: ADD k+1, WB k+2, done k+3.
- Each low mem_ready cycle adds exactly one cycle; the strobe stays asserted and elem is held.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Shared package `vec_ctrl_pkg` holds:
  - the state enum;
  - op constants OP_VLOAD/OP_VSTORE/OP_VADD/OP_ILL;
  - the TLoad all-ones helper, sized by VLEN.
- One sub-module, `vec_elem_counter`: IDX_W-bit counter with clear, increment and terminal-count flag (elem==VLEN-1). It is instantiated once.
- The FSM itself is a single two-process module: registered state, combinational outputs and next state.

## Test plan
- VLEN=4, VLOAD, mem_ready=1:
  - TLoad sequence 0001, 0010, 0100, 1000 on consecutive cycles, with AddrInc=1 on each.
  - Then VRFWrite=1 for one cycle, then done=1, 6 cycles after start.
- VSTORE with mem_ready low in cycles 2 and 3 after start:
  - MemWrite held through the stall.
  - Voutsel stays at 1 during the stall.
  - done arrives 2 cycles later than the no-stall case (cycle 7).
- VADD: VaddEn=1 with TLoad=1111 at cycle 1, VRFWrite at cycle 2, done at cycle 3; MemRead and MemWrite stay 0 throughout.
- `start` with op=11: err=1 for one cycle; busy stays 0; state stays IDLE; a following VADD runs normally.
- reset_n pulsed low during VLOAD at elem=2:
  - All outputs go to 0 immediately.
  - After release, a new VLOAD starts with TLoad=0001.
- `start` pulses during a VSTORE in progress are ignored: exactly one done, and elem never exceeds 3.
